// File: rtl/npu_seq_pkg.sv
// Shared types and encodings for the NPU frame sequencer.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package npu_seq_pkg;

  typedef enum logic [3:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT_NPU,
    S_STORE,
    S_TX_PREP,
    S_TX_SEND,
    S_TX_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] PH_LOAD    = 2'd0;
  localparam logic [1:0] PH_COMPUTE = 2'd1;
  localparam logic [1:0] PH_TX      = 2'd2;
  localparam logic [1:0] PH_END     = 2'd3;

  // Four 16-bit result words per group, sent one byte at a time.
  localparam int BYTES_PER_GROUP = 8;
  localparam logic [2:0] LAST_TX_BYTE = 3'(BYTES_PER_GROUP - 1);

  // Coarse frame phase reported to the host for each state.
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_LOAD:                           phase_of = PH_LOAD;
      S_ISSUE, S_WAIT_NPU, S_STORE:     phase_of = PH_COMPUTE;
      S_TX_PREP, S_TX_SEND, S_TX_WAIT:  phase_of = PH_TX;
      default:                          phase_of = PH_END;
    endcase
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Watchdog counter: expire is high on the LIMIT-th consecutive enabled cycle.
// Latency: expire is decoded from the registered count (same cycle as the count match).
// Backpressure: none; LIMIT=0 disables the watchdog and expire never asserts.
module seq_timeout_counter
  import npu_seq_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [W-1:0] cnt;

  assign expire = (LIMIT != 0) && en && (cnt == LAST);

  // Count enabled cycles; hold at the expiry value so the count never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire && (LIMIT != 0)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/npu_sequencer.sv
// Frame sequencer: load UART bytes, issue NPU groups, store results, stream them back.
// Latency: last rx_done -> npu_enable next cycle; npu_done -> out_we next cycle; tx_done -> tx_en in 1 (same group) or 2 cycles.
// Backpressure: waits indefinitely on rx_done/tx_done; npu_done wait is watchdog-bounded unless NPU_TIMEOUT is 0.
module npu_sequencer
  import npu_seq_pkg::*;
#(
  parameter int IMG_BYTES    = 65536,
  parameter int NUM_GROUPS   = 8192,
  parameter int GROUP_STRIDE = 8,
  parameter int ADDR_W       = 16,
  parameter int NPU_TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              npu_enable,
  input  logic              npu_done,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              tx_en,
  output logic [2:0]        tx_byte_sel,
  input  logic              tx_done,
  output logic [1:0]        phase,
  output logic              frame_done,
  output logic              error,
  output logic              rx_overrun
);

  localparam int BW = (IMG_BYTES < 2) ? 1 : $clog2(IMG_BYTES);
  localparam int GW = (NUM_GROUPS < 2) ? 1 : $clog2(NUM_GROUPS);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(IMG_BYTES - 1);
  localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);

  state_t          state, state_n;
  logic [BW-1:0]   byte_cnt, byte_cnt_n;
  logic [GW-1:0]   group, group_n;
  logic [2:0]      byte_idx, byte_idx_n;
  logic [ADDR_W-1:0] group_base_n;
  logic            npu_expire;

  // Input-memory base of the group about to be issued; truncation is intended.
  assign group_base_n = ADDR_W'(32'(group_n) * 32'(GROUP_STRIDE));

  seq_timeout_counter #(
    .LIMIT (NPU_TIMEOUT)
  ) u_npu_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != S_WAIT_NPU) || clear),
    .en     (state == S_WAIT_NPU),
    .expire (npu_expire)
  );

  // Next state and counter values; clear overrides everything, counters saturate.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    group_n    = group;
    byte_idx_n = byte_idx;
    if (clear) begin
      state_n    = S_LOAD;
      byte_cnt_n = '0;
      group_n    = '0;
      byte_idx_n = '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (rx_done) begin
            if (byte_cnt == LAST_BYTE) begin
              state_n = S_ISSUE;
              group_n = '0;
            end else begin
              byte_cnt_n = byte_cnt + BW'(1);
            end
          end
        end
        S_ISSUE: state_n = S_WAIT_NPU;
        S_WAIT_NPU: begin
          // A result arriving on the expiry cycle still counts.
          if (npu_done) begin
            state_n = S_STORE;
          end else if (npu_expire) begin
            state_n = S_ERR;
          end
        end
        S_STORE: begin
          if (group == LAST_GROUP) begin
            state_n    = S_TX_PREP;
            group_n    = '0;
            byte_idx_n = '0;
          end else begin
            state_n = S_ISSUE;
            group_n = group + GW'(1);
          end
        end
        S_TX_PREP: state_n = S_TX_SEND;
        S_TX_SEND: state_n = S_TX_WAIT;
        S_TX_WAIT: begin
          if (tx_done) begin
            if (byte_idx != LAST_TX_BYTE) begin
              state_n    = S_TX_SEND;
              byte_idx_n = byte_idx + 3'd1;
            end else if (group != LAST_GROUP) begin
              state_n    = S_TX_PREP;
              group_n    = group + GW'(1);
              byte_idx_n = '0;
            end else begin
              state_n = S_DONE;
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // State, counters and all outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_LOAD;
      byte_cnt    <= '0;
      group       <= '0;
      byte_idx    <= '0;
      mem_we      <= 1'b1;
      mem_addr    <= '0;
      npu_enable  <= 1'b0;
      out_we      <= 1'b0;
      out_addr    <= '0;
      tx_en       <= 1'b0;
      tx_byte_sel <= '0;
      phase       <= PH_LOAD;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      group       <= group_n;
      byte_idx    <= byte_idx_n;
      mem_we      <= (state_n == S_LOAD);
      npu_enable  <= (state_n == S_ISSUE);
      out_we      <= (state_n == S_STORE);
      tx_en       <= (state_n == S_TX_SEND);
      frame_done  <= (state_n == S_DONE);
      error       <= (state_n == S_ERR);
      phase       <= phase_of(state_n);
      out_addr    <= ADDR_W'(group_n);
      tx_byte_sel <= byte_idx_n;
      if (state_n == S_LOAD) begin
        mem_addr <= ADDR_W'(byte_cnt_n);
      end else if (state_n == S_ISSUE) begin
        mem_addr <= group_base_n;
      end
      if (clear) begin
        rx_overrun <= 1'b0;
      end else if (rx_done && (state != S_LOAD)) begin
        rx_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_sequencer.sv
// Directed bench for npu_sequencer: table-driven load/compute vectors plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_npu_sequencer;

  logic clk = 1'b0;
  logic rst, clear, rx_done, npu_done, tx_done;

  logic        mem_we, npu_enable, out_we, tx_en, frame_done, error, rx_overrun;
  logic [15:0] mem_addr, out_addr;
  logic [2:0]  tx_byte_sel;
  logic [1:0]  phase;

  logic        z_mem_we, z_npu_enable, z_out_we, z_tx_en, z_frame_done, z_error, z_rx_overrun;
  logic [15:0] z_mem_addr, z_out_addr;
  logic [2:0]  z_tx_byte_sel;
  logic [1:0]  z_phase;

  always #5 clk = ~clk;

  npu_sequencer #(
    .IMG_BYTES(16), .NUM_GROUPS(2), .GROUP_STRIDE(8), .ADDR_W(16), .NPU_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .rx_done(rx_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .npu_enable(npu_enable), .npu_done(npu_done),
    .out_we(out_we), .out_addr(out_addr), .tx_en(tx_en), .tx_byte_sel(tx_byte_sel),
    .tx_done(tx_done), .phase(phase), .frame_done(frame_done), .error(error),
    .rx_overrun(rx_overrun)
  );

  npu_sequencer #(
    .IMG_BYTES(16), .NUM_GROUPS(2), .GROUP_STRIDE(8), .ADDR_W(16), .NPU_TIMEOUT(0)
  ) dut_nowd (
    .clk(clk), .rst(rst), .clear(clear), .rx_done(rx_done),
    .mem_we(z_mem_we), .mem_addr(z_mem_addr), .npu_enable(z_npu_enable), .npu_done(npu_done),
    .out_we(z_out_we), .out_addr(z_out_addr), .tx_en(z_tx_en), .tx_byte_sel(z_tx_byte_sel),
    .tx_done(tx_done), .phase(z_phase), .frame_done(z_frame_done), .error(z_error),
    .rx_overrun(z_rx_overrun)
  );

  typedef struct packed {
    logic        rx, npu, tx;
    logic        we;
    logic [15:0] ma;
    logic        ne, ow;
    logic [15:0] oa;
    logic        te;
    logic [2:0]  sel;
    logic [1:0]  ph;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  int n_npu = 0, n_owe = 0, n_tx = 0;

  localparam logic [43:0] RST_BITS = {1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (npu_enable) n_npu = n_npu + 1;
    if (out_we)     n_owe = n_owe + 1;
    if (tx_en)      n_tx  = n_tx + 1;
  end

  function automatic logic [43:0] got1();
    return {mem_we, mem_addr, npu_enable, out_we, out_addr, tx_en, tx_byte_sel, phase,
            frame_done, error, rx_overrun};
  endfunction

  function automatic logic [43:0] got2();
    return {z_mem_we, z_mem_addr, z_npu_enable, z_out_we, z_out_addr, z_tx_en, z_tx_byte_sel,
            z_phase, z_frame_done, z_error, z_rx_overrun};
  endfunction

  function automatic logic [43:0] exp_bits(input vec_t v);
    return {v.we, v.ma, v.ne, v.ow, v.oa, v.te, v.sel, v.ph, 1'b0, 1'b0, v.ov};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int rx, input int npu, input int tx, input int clr);
    rx_done  = (rx != 0);
    npu_done = (npu != 0);
    tx_done  = (tx != 0);
    clear    = (clr != 0);
    @(posedge clk);
    #1;
    rx_done  = 1'b0;
    npu_done = 1'b0;
    tx_done  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic add(input int rx, input int npu, input int tx, input int we, input int ma,
                     input int ne, input int ow, input int oa, input int te, input int sel,
                     input int ph, input int ov);
    vec_t v;
    v.rx = 1'(rx);  v.npu = 1'(npu); v.tx = 1'(tx);
    v.we = 1'(we);  v.ma = 16'(ma);  v.ne = 1'(ne); v.ow = 1'(ow);
    v.oa = 16'(oa); v.te = 1'(te);   v.sel = 3'(sel); v.ph = 2'(ph); v.ov = 1'(ov);
    vecs.push_back(v);
  endtask

  // Load (with strays), then two groups with the NPU answering 5 cycles after enable.
  task automatic build_table();
    add(0,1,0, 1,0, 0,0,0, 0,0,0, 0);         // stray npu_done in LOAD
    add(0,0,1, 1,0, 0,0,0, 0,0,0, 0);         // stray tx_done in LOAD
    for (int k = 0; k < 15; k++) begin
      add(1,0,0, 1,k+1, 0,0,0, 0,0,0, 0);
      if (k == 7) add(0,0,0, 1,8, 0,0,0, 0,0,0, 0);
    end
    add(1,0,0, 0,0, 1,0,0, 0,0,1, 0);         // 16th byte -> ISSUE group 0
    add(0,0,1, 0,0, 0,0,0, 0,0,1, 0);         // stray tx_done in ISSUE
    add(1,0,0, 0,0, 0,0,0, 0,0,1, 1);         // rx_done in WAIT_NPU
    for (int k = 0; k < 3; k++) add(0,0,0, 0,0, 0,0,0, 0,0,1, 1);
    add(0,1,0, 0,0, 0,1,0, 0,0,1, 1);         // STORE group 0
    add(0,0,0, 0,8, 1,0,1, 0,0,1, 1);         // ISSUE group 1
    for (int k = 0; k < 5; k++) add(0,0,0, 0,8, 0,0,1, 0,0,1, 1);
    add(0,1,0, 0,8, 0,1,1, 0,0,1, 1);         // STORE group 1
    add(0,0,0, 0,8, 0,0,0, 0,0,2, 1);         // TX_PREP group 0
    add(0,0,0, 0,8, 0,0,0, 1,0,2, 1);         // TX_SEND byte 0
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(int'(vecs[i].rx), int'(vecs[i].npu), int'(vecs[i].tx), 0);
      chk($sformatf("vec%0d", i), 64'(got1()), 64'(exp_bits(vecs[i])));
    end
  endtask

  // Transmit 2 groups x 8 bytes with tx_done 3 cycles after each tx_en.
  task automatic run_tx();
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < 8; b++) begin
        chk("tx_send", 64'({tx_en, tx_byte_sel, out_addr, phase}), 64'({1'b1, 3'(b), 16'(g), 2'd2}));
        cyc(0,0,0,0);
        chk("tx_en_pulse", 64'({tx_en, phase}), 64'({1'b0, 2'd2}));
        cyc(0,0,0,0);
        cyc(0,0,0,0);
        cyc(0,0,1,0);
        if (b == 7) begin
          if (g == 0) begin
            chk("tx_prep", 64'({tx_en, phase, out_addr, tx_byte_sel}), 64'({1'b0, 2'd2, 16'd1, 3'd0}));
            cyc(0,0,0,0);
          end else begin
            chk("frame_done", 64'({frame_done, phase, tx_en, error}), 64'({1'b1, 2'd3, 1'b0, 1'b0}));
          end
        end
      end
    end
    repeat (3) cyc(0,1,1,0);
    chk("done_held", 64'({frame_done, phase, tx_en, npu_enable}), 64'({1'b1, 2'd3, 1'b0, 1'b0}));
  endtask

  task automatic run_frame(input string nm);
    int a, b, c;
    a = n_npu; b = n_owe; c = n_tx;
    run_table();
    run_tx();
    chk({nm, "_npu_pulses"}, 64'(n_npu - a), 64'd2);
    chk({nm, "_owe_pulses"}, 64'(n_owe - b), 64'd2);
    chk({nm, "_tx_pulses"}, 64'(n_tx - c), 64'd16);
  endtask

  task automatic load_all();
    for (int k = 0; k < 16; k++) cyc(1,0,0,0);
    chk("issue_after_load", 64'({npu_enable, mem_we, mem_addr, phase}), 64'({1'b1, 1'b0, 16'd0, 2'd1}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400us");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; clear = 1'b0; rx_done = 1'b0; npu_done = 1'b0; tx_done = 1'b0;
    build_table();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 64'(got1()), 64'(RST_BITS));
    rst = 1'b1;
    chk("reset_state", 64'(got1()), 64'(RST_BITS));
    chk("reset_state_nowd", 64'(got2()), 64'(RST_BITS));

    // Frame A: 5-cycle NPU, full transmit.
    run_frame("A");

    // Frame B: zero-delay NPU, then clear mid-transmit.
    cyc(0,0,0,1);
    chk("clear_from_done", 64'(got1()), 64'(RST_BITS));
    load_all();
    cyc(1,0,0,0);
    chk("ovr_in_compute", 64'({rx_overrun, phase, mem_addr, mem_we}), 64'({1'b1, 2'd1, 16'd0, 1'b0}));
    cyc(0,1,0,0);
    chk("zd_store0", 64'({out_we, out_addr}), 64'({1'b1, 16'd0}));
    cyc(0,0,0,0);
    chk("zd_issue1", 64'({npu_enable, mem_addr, out_we}), 64'({1'b1, 16'd8, 1'b0}));
    cyc(0,0,0,0);
    cyc(0,1,0,0);
    chk("zd_store1", 64'({out_we, out_addr}), 64'({1'b1, 16'd1}));
    cyc(0,0,0,0);
    chk("zd_tx_prep", 64'({phase, tx_en}), 64'({2'd2, 1'b0}));
    cyc(0,0,0,0);
    chk("zd_tx_send", 64'({tx_en, tx_byte_sel}), 64'({1'b1, 3'd0}));
    cyc(0,0,0,0);
    cyc(0,0,0,1);
    chk("clear_mid_tx", 64'(got1()), 64'(RST_BITS));

    // Frame C after clear must replay identically.
    run_frame("C");

    // NPU never answers: watchdog fires 20 cycles into WAIT_NPU.
    cyc(0,0,0,1);
    load_all();
    repeat (20) cyc(0,0,0,0);
    chk("to_before", 64'({error, phase}), 64'({1'b0, 2'd1}));
    cyc(0,0,0,0);
    chk("to_expire", 64'({error, phase, frame_done}), 64'({1'b1, 2'd3, 1'b0}));
    repeat (1000) cyc(0,0,0,0);
    chk("no_timeout_when_0", 64'({z_error, z_phase}), 64'({1'b0, 2'd1}));
    chk("err_held", 64'({error, phase}), 64'({1'b1, 2'd3}));
    cyc(0,0,0,1);
    chk("clear_from_err", 64'(got1()), 64'(RST_BITS));
    chk("clear_nowd", 64'(got2()), 64'(RST_BITS));

    // npu_done on the expiry cycle wins.
    load_all();
    repeat (20) cyc(0,0,0,0);
    chk("edge_before", 64'(error), 64'd0);
    cyc(0,1,0,0);
    chk("done_wins", 64'({out_we, error, phase}), 64'({1'b1, 1'b0, 2'd1}));

    // Asynchronous reset mid-compute.
    cyc(0,0,0,0);
    cyc(0,0,0,0);
    #3 rst = 1'b0;
    #1;
    chk("async_reset", 64'(got1()), 64'(RST_BITS));
    chk("async_reset_nowd", 64'(got2()), 64'(RST_BITS));
    @(posedge clk);
    #1;
    chk("reset_held", 64'(got1()), 64'(RST_BITS));
    rst = 1'b1;

    // Frame D after reset must replay identically.
    run_frame("D");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_sequencer.md
# npu_sequencer

Frame-level controller for the UART-fed NPU pipeline. Sequences three phases per frame:
- **Load:** incoming UART bytes are written into the input memory.
- **Compute:** groups of four 16-bit pixels are issued to the NPU one at a time, and each result is stored into the output memory.
- **Transmit:** every result byte is streamed back through the UART transmitter under a tx_en/tx_done handshake.

It replaces the free-running counters and comparators around the input memory, NPU and output memory with one explicit state machine.

## Interface
Parameters:
- IMG_BYTES, 65536, bytes loaded per frame
- NUM_GROUPS, 8192, NPU groups per frame (four 16-bit pixels each)
- GROUP_STRIDE, 8, input-memory byte-address step between groups
- ADDR_W, 16, memory address width
- NPU_TIMEOUT, 1023, max cycles waiting for npu_done; 0 disables the timeout

Ports (one clock, clk; reset rst is asynchronous and active-low):
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous frame restart; highest priority after rst
- rx_done  in  1  one-cycle pulse per received UART byte
- mem_we  out  1  input-memory write enable
- mem_addr  out  ADDR_W  input-memory address: byte address in load, group base in compute
- npu_enable  out  1  one-cycle NPU start pulse
- npu_done  in  1  one-cycle NPU result-valid pulse
- out_we  out  1  output-memory write enable (one-cycle pulse)
- out_addr  out  ADDR_W  output-memory address (group index)
- tx_en  out  1  one-cycle UART transmit request
- tx_byte_sel  out  3  result byte to transmit (0 = word0[7:0] … 7 = word3[15:8])
- tx_done  in  1  one-cycle UART byte-sent pulse
- phase  out  2  0 load, 1 compute, 2 transmit, 3 done/error
- frame_done  out  1  held high in DONE
- error  out  1  held high in ERR (NPU timeout)
- rx_overrun  out  1  sticky: rx_done seen outside LOAD

## Operation
States: LOAD, ISSUE, WAIT_NPU, STORE, TX_PREP, TX_SEND, TX_WAIT, DONE, ERR. All outputs are registered or decoded from registered state.

| State | Outputs | Transition |
|---|---|---|
| LOAD | mem_we=1, mem_addr=byte_cnt | Each rx_done increments byte_cnt. rx_done with byte_cnt==IMG_BYTES-1 → ISSUE, group=0. |
| ISSUE | npu_enable=1 for exactly one cycle, mem_addr=group*GROUP_STRIDE (truncated to ADDR_W) | → WAIT_NPU |
| WAIT_NPU | mem_addr held, wait counter increments | npu_done → STORE. Counter reaching NPU_TIMEOUT (nonzero) → ERR. |
| STORE | out_we=1, out_addr=group | Last group → TX_PREP with group=0, byte=0. Otherwise group+1 → ISSUE. |
| TX_PREP | out_addr=group | One-cycle bubble that absorbs the output-memory synchronous read latency → TX_SEND |
| TX_SEND | tx_en=1, tx_byte_sel=byte | → TX_WAIT |
| TX_WAIT | | On tx_done: byte<7 → byte+1, TX_SEND. Byte 7, not last group → group+1, byte=0, TX_PREP. Byte 7, last group → DONE. |
| DONE / ERR | frame_done / error held | Held until clear |

Boundary and priority rules:
- clear (from any state): state=LOAD, all counters zero, all flags zero.
- npu_done in the same cycle as timeout expiry: done wins.
- npu_done outside WAIT_NPU and tx_done outside TX_WAIT: ignored.
- rx_done outside LOAD: ignored and sets rx_overrun.
- Counters never wrap. byte_cnt is wide enough to hold IMG_BYTES-1; group is wide enough to hold NUM_GROUPS-1.

## Timing
Reset values:
- state LOAD, so mem_we=1 and phase=0
- mem_addr=0
- all other outputs 0
- counters 0

Latencies:
- Final rx_done at edge t → npu_enable high during cycle t+1.
- npu_done in cycle t → out_we high in cycle t+1 → next npu_enable in cycle t+2.
- Minimum compute cost is 3 cycles per group.
- TX_PREP → TX_SEND: 1 cycle. tx_done in cycle t → next tx_en at t+1 (same group) or t+2 (new group).
- Reset asserted mid-frame: immediate return to reset values; any partial frame is discarded.

## Structure
- Package npu_seq_pkg holds the state enum, phase encodings (PH_LOAD, PH_COMPUTE, PH_TX, PH_END) and the byte-per-group constant 8.
- One sub-module, seq_timeout_counter: clear/enable/expire, parameterised by limit, with 0 meaning disabled. It is used for the WAIT_NPU watchdog.

## Test plan
All scenarios use IMG_BYTES=16, NUM_GROUPS=2, GROUP_STRIDE=8, NPU_TIMEOUT=20 unless stated.
- **Load:** 16 rx_done pulses → mem_addr 0..15 with mem_we=1; after the 16th, mem_we=0 and npu_enable pulses once with mem_addr=0.
- **Compute:** NPU model returns done 5 cycles after each enable → out_we pulses with out_addr=0 then 1, and second npu_enable has mem_addr=8. Zero-delay done (next cycle) → 3 cycles per group.
- **Transmit:** tx_done 3 cycles after each tx_en → 16 tx_en pulses, tx_byte_sel 0..7 twice, out_addr 0 then 1, TX_PREP bubble between groups; then frame_done=1, phase=3.
- **Timeout:** NPU never answers → error=1 exactly 20 cycles into WAIT_NPU. Done and expiry in the same cycle → STORE, no error. With NPU_TIMEOUT=0, waiting 1000 cycles → no error.
- **Spurious inputs:** rx_done during compute → rx_overrun=1, counters unchanged. Stray npu_done in LOAD and stray tx_done in ISSUE → no effect.
- **Restart:** clear mid-TX_WAIT → next cycle LOAD, flags 0, mem_addr=0. rst low mid-compute → all outputs at reset values asynchronously. A full second frame after either → identical output sequence.
